// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv unit signal bundle.
//
// Handshake: EX raises start (or mf_req / mt_req) and holds it, together with
// op and operands, while stall is high. The request is taken on the first
// rising edge where it is high, flush_ex is low and stall is low (unit idle).
// flush_ex squashes the request for that cycle. done pulses for one cycle
// after HI/LO are committed; at that point busy is already low.
interface muldiv_if #(parameter int XLEN = muldiv_pkg::MD_XLEN);
  import muldiv_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic            flush_ex;
  logic            abort;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            mf_req;
  logic [1:0]      mt_req;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  state_t          dbg_state;

  modport master (
    output start, op, flush_ex, abort, rs_val, rt_val, mf_req, mt_req,
    input  busy, stall, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, flush_ex, abort, rs_val, rt_val, mf_req, mt_req,
    output busy, stall, done, hi, lo, dbg_state
  );

endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned shift-add multiplier / restoring divider.
// acc layout: [2*XLEN:XLEN] upper (partial product / partial remainder),
//             [XLEN-1:0]    lower (multiplier bits / dividend -> quotient).
module muldiv_iter import muldiv_pkg::*; #(
  parameter int XLEN = MD_XLEN
) (
  input  logic [2*XLEN:0]  acc,
  input  logic [XLEN-1:0]  operand,
  input  logic             is_div,
  output logic [2*XLEN:0]  acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [2*XLEN:0] shl;

  // Multiply: add multiplicand on LSB, shift right. Divide: shift left, trial subtract.
  always_comb begin
    sum   = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    shl   = {acc[2*XLEN-1:0], 1'b0};
    trial = shl[2*XLEN:XLEN] - {1'b0, operand};
    if (is_div) begin
      // Borrow out of the trial means the divisor did not fit: keep shifted value.
      if (trial[XLEN]) acc_next = shl;
      else             acc_next = {trial, shl[XLEN-1:1], 1'b1};
    end else begin
      acc_next = {1'b0, sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO.
// Operands are converted to magnitudes at launch, iterated XLEN times through
// muldiv_iter, then sign-corrected and committed in the FIX state.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 5
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN:0]   acc_q, acc_nx;
  logic [XLEN-1:0]   opnd_q, hi_q, lo_q;
  logic              is_div_q, neg_res_q, neg_rem_q, done_q;

  logic              busy, launch, mt_go, last_iter;
  logic              signed_op, div_zero;
  logic [XLEN-1:0]   rs_abs, rt_abs;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign busy      = (state_q != IDLE);
  assign launch    = (state_q == IDLE) & bus.start & ~bus.flush_ex & ~bus.abort;
  // A simultaneous start always shadows an MT request.
  assign mt_go     = (state_q == IDLE) & ~bus.start & ~bus.flush_ex & (|bus.mt_req);
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));
  assign signed_op = ~bus.op[0];
  // Divide by zero keeps the raw dividend so HI ends up as the original rs_val.
  assign div_zero  = bus.op[1] & (bus.rt_val == '0);
  assign rs_abs    = (signed_op & ~div_zero & bus.rs_val[XLEN-1]) ? -bus.rs_val : bus.rs_val;
  assign rt_abs    = (signed_op & bus.rt_val[XLEN-1]) ? -bus.rt_val : bus.rt_val;

  assign prod_fix  = neg_res_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign quo_fix   = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (is_div_q),
    .acc_next (acc_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: launch, XLEN iterations, one fix-up edge, abort to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (bus.abort) state_d = IDLE;
               else if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO commit and MTHI/MTLO writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            is_div_q  <= bus.op[1];
            neg_res_q <= signed_op & ~div_zero & (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
            neg_rem_q <= signed_op & ~div_zero & bus.op[1] & bus.rs_val[XLEN-1];
            acc_q     <= {{(XLEN+1){1'b0}}, rs_abs};
            opnd_q    <= rt_abs;
            cnt_q     <= '0;
          end else if (mt_go) begin
            if (bus.mt_req[1]) hi_q <= bus.rs_val;
            if (bus.mt_req[0]) lo_q <= bus.rs_val;
          end
        end
        RUN: begin
          if (!bus.abort) begin
            acc_q <= acc_nx;
            if (!last_iter) cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          if (!bus.abort) begin
            if (is_div_q) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end else begin
              hi_q <= prod_fix[2*XLEN-1:XLEN];
              lo_q <= prod_fix[XLEN-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.stall     = busy & (bus.start | bus.mf_req | (|bus.mt_req)) & ~bus.flush_ex;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, signed/unsigned results, divide
// corner cases, stall behaviour, abort/flush, reset mid-operation, MTHI/MTLO.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    bus.start = 0; bus.op = 0; bus.flush_ex = 0; bus.abort = 0;
    bus.rs_val = 0; bus.rt_val = 0; bus.mf_req = 0; bus.mt_req = 0;
  endtask

  // Returns at the falling edge right after the launching edge E0.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 0;
  endtask

  // Observes 40 cycles from the post-E0 falling edge (index 0).
  task automatic watch(output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    idle_in();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.hi !== 32'h0)  begin n_bad++; $display("FAIL rst_hi: got %h expected %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0)  begin n_bad++; $display("FAIL rst_lo: got %h expected %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", bus.stall); end
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_bad++; $display("FAIL rst_state: got %0d expected %0d", bus.dbg_state, IDLE); end
  endtask

  task automatic test_multu_latency();
    int b_n, d_n, d_at;
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    watch(b_n, d_n, d_at);
    n_cmp++; if (b_n !== 33)  begin n_bad++; $display("FAIL multu_busy_cycles: got %0d expected 33", b_n); end
    n_cmp++; if (d_n !== 1)   begin n_bad++; $display("FAIL multu_done_pulses: got %0d expected 1", d_n); end
    n_cmp++; if (d_at !== 33) begin n_bad++; $display("FAIL multu_done_cycle: got %0d expected 33", d_at); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h expected %h", bus.hi, 32'hFFFF_FFFE); end
    n_cmp++; if (bus.lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h expected %h", bus.lo, 32'h1); end
  endtask

  task automatic test_signed();
    int b_n, d_n, d_at;
    launch(MD_MULT, 32'hFFFF_FFF9, 32'd3);   // -7 * 3 = -21
    watch(b_n, d_n, d_at);
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi: got %h expected %h", bus.hi, 32'hFFFF_FFFF); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo: got %h expected %h", bus.lo, 32'hFFFF_FFEB); end
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);    // -7 / 2 = -3 rem -1
    watch(b_n, d_n, d_at);
    n_cmp++; if (d_at !== 33) begin n_bad++; $display("FAIL div_done_cycle: got %0d expected 33", d_at); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_quo: got %h expected %h", bus.lo, 32'hFFFF_FFFD); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_rem: got %h expected %h", bus.hi, 32'hFFFF_FFFF); end
  endtask

  task automatic test_div_corners();
    int b_n, d_n, d_at;
    launch(MD_DIVU, 32'd100, 32'd0);
    watch(b_n, d_n, d_at);
    n_cmp++; if (b_n !== 33) begin n_bad++; $display("FAIL divu0_busy_cycles: got %0d expected 33", b_n); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu0_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFF); end
    n_cmp++; if (bus.hi !== 32'd100) begin n_bad++; $display("FAIL divu0_hi: got %h expected %h", bus.hi, 32'd100); end
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd0);    // signed divide by zero keeps raw dividend
    watch(b_n, d_n, d_at);
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div0_lo: got %h expected %h", bus.lo, 32'hFFFF_FFFF); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL div0_hi: got %h expected %h", bus.hi, 32'hFFFF_FFF9); end
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    watch(b_n, d_n, d_at);
    n_cmp++; if (bus.lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo: got %h expected %h", bus.lo, 32'h8000_0000); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi: got %h expected %h", bus.hi, 32'h0); end
  endtask

  task automatic test_mf_stall();
    int   stall_n, done_i;
    logic done_stall;
    logic [31:0] done_lo, done_hi;
    stall_n = 0; done_i = -1; done_stall = 1'bx; done_lo = 'x; done_hi = 'x;
    launch(MD_DIVU, 32'd100, 32'd7);         // 14 rem 2
    for (int i = 0; i < 40 && done_i < 0; i++) begin
      if (i >= 5) bus.mf_req = 1;
      #1;
      if (bus.done) begin
        done_i = i; done_stall = bus.stall; done_lo = bus.lo; done_hi = bus.hi;
      end else if (bus.stall) begin
        stall_n++;
      end
      @(negedge clk);
    end
    bus.mf_req = 0;
    n_cmp++; if (done_i !== 33) begin n_bad++; $display("FAIL mf_done_cycle: got %0d expected 33", done_i); end
    n_cmp++; if (stall_n !== 28) begin n_bad++; $display("FAIL mf_stall_cycles: got %0d expected 28", stall_n); end
    n_cmp++; if (done_stall !== 1'b0) begin n_bad++; $display("FAIL mf_stall_on_done: got %b expected 0", done_stall); end
    n_cmp++; if (done_lo !== 32'd14) begin n_bad++; $display("FAIL mf_lo_on_done: got %h expected %h", done_lo, 32'd14); end
    n_cmp++; if (done_hi !== 32'd2) begin n_bad++; $display("FAIL mf_hi_on_done: got %h expected %h", done_hi, 32'd2); end
  endtask

  task automatic test_abort_flush();
    int b_n, d_n, d_at;
    @(negedge clk); bus.mt_req = 2'b10; bus.rs_val = 32'h11;
    @(negedge clk); bus.mt_req = 2'b01; bus.rs_val = 32'h22;
    @(negedge clk); bus.mt_req = 2'b00;
    n_cmp++; if (bus.hi !== 32'h11) begin n_bad++; $display("FAIL mthi_setup: got %h expected %h", bus.hi, 32'h11); end
    n_cmp++; if (bus.lo !== 32'h22) begin n_bad++; $display("FAIL mtlo_setup: got %h expected %h", bus.lo, 32'h22); end
    launch(MD_MULT, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    watch(b_n, d_n, d_at);
    n_cmp++; if (d_n !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", d_n); end
    n_cmp++; if (bus.hi !== 32'h11) begin n_bad++; $display("FAIL abort_hi: got %h expected %h", bus.hi, 32'h11); end
    n_cmp++; if (bus.lo !== 32'h22) begin n_bad++; $display("FAIL abort_lo: got %h expected %h", bus.lo, 32'h22); end
    // start squashed by flush_ex
    bus.start = 1; bus.flush_ex = 1; bus.op = MD_MULTU; bus.rs_val = 3; bus.rt_val = 4;
    @(negedge clk);
    bus.start = 0; bus.flush_ex = 0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy: got %b expected 0", bus.busy); end
    // start blocked by abort in IDLE
    bus.start = 1; bus.abort = 1;
    @(negedge clk);
    bus.start = 0; bus.abort = 0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    launch(MD_MULTU, 32'd3, 32'd4);
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_busy: got %b expected 1", bus.busy); end
    rst_n = 0;
    #1;
    n_cmp++; if (bus.hi !== 32'h0)  begin n_bad++; $display("FAIL midrst_hi: got %h expected %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h0)  begin n_bad++; $display("FAIL midrst_lo: got %h expected %h", bus.lo, 32'h0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_mt();
    int   stall_n, done_i;
    logic done_stall;
    logic [31:0] done_lo;
    @(negedge clk); bus.mt_req = 2'b10; bus.rs_val = 32'hABCD;
    @(negedge clk); bus.mt_req = 2'b00;
    n_cmp++; if (bus.hi !== 32'hABCD) begin n_bad++; $display("FAIL mthi_idle: got %h expected %h", bus.hi, 32'hABCD); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL mthi_lo_untouched: got %h expected %h", bus.lo, 32'h0); end
    stall_n = 0; done_i = -1; done_stall = 1'bx; done_lo = 'x;
    launch(MD_MULTU, 32'd2, 32'd3);
    for (int i = 0; i < 40 && done_i < 0; i++) begin
      if (i >= 3) begin bus.mt_req = 2'b01; bus.rs_val = 32'h55; end
      #1;
      if (bus.done) begin
        done_i = i; done_stall = bus.stall; done_lo = bus.lo;
      end else if (bus.stall) begin
        stall_n++;
      end
      @(negedge clk);
    end
    // The MTLO is taken on the edge that closes the done cycle.
    bus.mt_req = 2'b00;
    n_cmp++; if (stall_n !== 30) begin n_bad++; $display("FAIL mt_stall_cycles: got %0d expected 30", stall_n); end
    n_cmp++; if (done_stall !== 1'b0) begin n_bad++; $display("FAIL mt_stall_on_done: got %b expected 0", done_stall); end
    n_cmp++; if (done_lo !== 32'd6) begin n_bad++; $display("FAIL mt_lo_on_done: got %h expected %h", done_lo, 32'd6); end
    n_cmp++; if (bus.lo !== 32'h55) begin n_bad++; $display("FAIL mtlo_after_done: got %h expected %h", bus.lo, 32'h55); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL mtlo_hi_kept: got %h expected %h", bus.hi, 32'h0); end
  endtask

  task automatic test_start_beats_mt();
    int b_n, d_n, d_at;
    @(negedge clk);
    bus.start = 1; bus.op = MD_MULTU; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.mt_req = 2'b11;
    @(negedge clk);
    bus.start = 0; bus.mt_req = 2'b00;
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL start_mt_hi: got %h expected %h", bus.hi, 32'h0); end
    n_cmp++; if (bus.lo !== 32'h55) begin n_bad++; $display("FAIL start_mt_lo: got %h expected %h", bus.lo, 32'h55); end
    watch(b_n, d_n, d_at);
    n_cmp++; if (bus.lo !== 32'd12) begin n_bad++; $display("FAIL start_mt_result: got %h expected %h", bus.lo, 32'd12); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_multu_latency();
    test_signed();
    test_div_corners();
    test_mf_stall();
    test_abort_flush();
    test_reset_mid();
    test_mt();
    test_start_beats_mt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
